universal_shift_register_param: RTL and testbench

UNIVERSAL_SHIFT_REGISTER_PARAM -- requirements
Module: universal_shift_register_param

---
 rtl/universal_shift_register_param.sv | 93 +++++++++
 tb/tb_universal_shift_register_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register_param.sv
// Universal shift register: hold, parallel load, logical shifts with serial
// fill, lossless rotates, arithmetic shift right and synchronous clear.
// Also keeps a saturating count of shift/rotate operations and a registered
// zero flag that always agrees with Q in the same cycle.
module universal_shift_register_param #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter int                 CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerInL,
    input  logic             SerInR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             Zero,
    output logic [CNT_W-1:0] ShiftCnt
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             is_shift;

    // Next register value selected by Mode; serial inputs only reach the
    // two logical shift arms.
    always_comb begin
        q_d = q_q;
        case (Mode)
            MODE_HOLD: q_d = q_q;
            MODE_LOAD: q_d = D;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], SerInL};
            MODE_SHR:  q_d = {SerInR, q_q[WIDTH-1:1]};
            MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            MODE_CLR:  q_d = RESET_VALUE;
        endcase
    end

    // Shift-event counter: saturates rather than wrapping, cleared by load
    // and clear, untouched by hold.
    always_comb begin
        is_shift = (Mode >= MODE_SHL) && (Mode <= MODE_ASR);
        cnt_d    = cnt_q;
        if (is_shift) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if ((Mode == MODE_LOAD) || (Mode == MODE_CLR)) begin
            cnt_d = '0;
        end
    end

    // Zero is computed from the next value so it lands on the same edge as Q.
    always_comb begin
        zero_d = (q_d == '0);
    end

    // State registers: async reset dominates, En gates every update.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            q_q    <= RESET_VALUE;
            cnt_q  <= '0;
            zero_q <= (RESET_VALUE == '0);
        end else if (En) begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign Q        = q_q;
    assign notQ     = ~q_q;
    assign Zero     = zero_q;
    assign ShiftCnt = cnt_q;

endmodule

// File: tb/tb_universal_shift_register_param.sv
module tb_universal_shift_register_param;

    localparam logic [7:0] RV = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;

    logic [7:0] q, nq, q3, nq3;
    logic       zero, zero3;
    logic [7:0] cnt;
    logic [2:0] cnt3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] cnt;
        logic [2:0] cnt3;
        logic       zero;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_q;
    logic [7:0] m_cnt;
    logic [2:0] m_cnt3;

    universal_shift_register_param #(.WIDTH(8), .RESET_VALUE(RV), .CNT_W(8)) dut (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .D(d),
        .SerInL(sl), .SerInR(sr), .Q(q), .notQ(nq), .Zero(zero), .ShiftCnt(cnt)
    );

    universal_shift_register_param #(.WIDTH(8), .RESET_VALUE(RV), .CNT_W(3)) dut_sat (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .D(d),
        .SerInL(sl), .SerInR(sr), .Q(q3), .notQ(nq3), .Zero(zero3), .ShiftCnt(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic [2:0] md,
                                            input logic [7:0] din, input logic l, input logic r);
        case (md)
            3'd1:    return din;
            3'd2:    return {cur[6:0], l};
            3'd3:    return {r, cur[7:1]};
            3'd4:    return {cur[6:0], cur[7]};
            3'd5:    return {cur[0], cur[7:1]};
            3'd6:    return {cur[7], cur[7:1]};
            3'd7:    return RV;
            default: return cur;
        endcase
    endfunction

    task automatic model_reset();
        m_q    = RV;
        m_cnt  = 8'd0;
        m_cnt3 = 3'd0;
        sb.delete();
    endtask

    // Drive one cycle at the negedge, push the expectation, check after the edge.
    task automatic step(input logic e, input logic [2:0] md, input logic [7:0] din,
                        input logic l, input logic r);
        exp_t ex;
        en = e; mode = md; d = din; sl = l; sr = r;
        if (e) begin
            m_q = ref_next(m_q, md, din, l, r);
            if (md >= 3'd2 && md <= 3'd6) begin
                if (m_cnt != 8'hFF) m_cnt++;
                if (m_cnt3 != 3'd7) m_cnt3++;
            end else if (md == 3'd1 || md == 3'd7) begin
                m_cnt  = 8'd0;
                m_cnt3 = 3'd0;
            end
        end
        ex.q = m_q; ex.cnt = m_cnt; ex.cnt3 = m_cnt3; ex.zero = (m_q == 8'd0);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        checks++;
        if (q !== ex.q || q3 !== ex.q) begin
            failures++;
            $display("FAIL q: got %h/%h expected %h (mode %0d en %0b)", q, q3, ex.q, md, e);
        end
        checks++;
        if (nq !== ~ex.q) begin
            failures++;
            $display("FAIL notq: got %h expected %h", nq, ~ex.q);
        end
        checks++;
        if (zero !== ex.zero || zero3 !== ex.zero) begin
            failures++;
            $display("FAIL zero: got %b/%b expected %b", zero, zero3, ex.zero);
        end
        checks++;
        if (cnt !== ex.cnt || cnt3 !== ex.cnt3) begin
            failures++;
            $display("FAIL cnt: got %0d/%0d expected %0d/%0d", cnt, cnt3, ex.cnt, ex.cnt3);
        end
        @(negedge clk);
    endtask

    task automatic expect_lit(input string name, input logic [7:0] got, input logic [7:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (q !== RV || nq !== 8'h5A || cnt !== 8'd0 || cnt3 !== 3'd0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL %s: q=%h nq=%h cnt=%0d cnt3=%0d zero=%b expected a5 5a 0 0 0",
                     name, q, nq, cnt, cnt3, zero);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; mode = 3'd0; d = 8'd0; sl = 1'b0; sr = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        // pull reset between edges and look without any clock edge
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_load_shift();
        step(1'b1, 3'd1, 8'h81, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
        expect_lit("shl_q", q, 8'h07);
        expect_lit("shl_cnt", cnt, 8'd2);
        step(1'b1, 3'd3, 8'hFF, 1'b1, 1'b0);
        expect_lit("shr_q", q, 8'h03);
        expect_lit("shr_cnt", cnt, 8'd3);
    endtask

    task automatic test_rotate_asr();
        step(1'b1, 3'd1, 8'h96, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 3'd4, 8'h00, 1'b1, 1'b1);
        expect_lit("rol8_q", q, 8'h96);
        for (int i = 0; i < 8; i++) step(1'b1, 3'd5, 8'h00, 1'b1, 1'b0);
        expect_lit("ror8_q", q, 8'h96);
        step(1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        expect_lit("asr_q", q, 8'hCB);
    endtask

    task automatic test_enable_zero();
        step(1'b1, 3'd1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd2, 8'hAA, 1'b0, 1'b1);
        expect_lit("en_hold_q", q, 8'h01);
        expect_lit("en_hold_cnt", cnt, 8'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 3'd2, 8'hAA, 1'b0, 1'b1);
        expect_lit("shift_out_q", q, 8'h00);
        expect_lit("shift_out_zero", {7'd0, zero}, 8'd1);
        step(1'b1, 3'd0, 8'hFF, 1'b1, 1'b1);
        expect_lit("hold_cnt", cnt, 8'd8);
    endtask

    task automatic test_saturation();
        step(1'b1, 3'd1, 8'h5B, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2 == 0) ? 3'd4 : 3'd5, 8'h00, 1'b0, 1'b0);
        expect_lit("sat_cnt3", {5'd0, cnt3}, 8'd7);
        expect_lit("sat_cnt8", cnt, 8'd10);
        step(1'b1, 3'd7, 8'h00, 1'b1, 1'b1);
        expect_lit("clr_q", q, RV);
        expect_lit("clr_cnt3", {5'd0, cnt3}, 8'd0);
    endtask

    task automatic test_async_mid_shift();
        step(1'b1, 3'd1, 8'h6E, 1'b0, 1'b0);
        en = 1'b1; mode = 3'd4;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_shift");
        @(negedge clk);
        mode = 3'd4;
        @(posedge clk);
        #1 check_reset_outputs("reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 3'd1, 8'h3C, 1'b0, 1'b0);
        expect_lit("first_edge_load", q, 8'h3C);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate_asr();
        test_enable_zero();
        test_saturation();
        test_async_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
